// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared write-back control bit indices, state encoding and defaults
package wb_pkg;

   localparam int WB_REG_WRITE  = 0;
   localparam int WB_MEM_TO_REG = 1;
   localparam int WB_WIDE       = 2;

   localparam int DEFAULT_UPPER_DEST = 0;

   typedef enum logic {
      IDLE    = 1'b0,
      HI_PEND = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_data_select.sv
// rtl/wb_data_select.sv - write-back result mux between load data and ALU low half
module wb_data_select #(
   parameter int WIDTH = 16
) (
   input  logic             mem_to_reg,
   input  logic [WIDTH-1:0] alu_lower,
   input  logic [WIDTH-1:0] mem_data,
   output logic [WIDTH-1:0] result
);

   // Loads take memory data; everything else takes the low ALU half.
   always_comb begin
      result = mem_to_reg ? mem_data : alu_lower;
   end

endmodule

// File: rtl/wb_writeback_sequencer.sv
// rtl/wb_writeback_sequencer.sv - MEM/WB consumer sequencing one or two register-file writes
module wb_writeback_sequencer
   import wb_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ADDR_W     = 4,
   parameter int UPPER_DEST = DEFAULT_UPPER_DEST
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [WIDTH-1:0]  WB_CTRL,
   input  logic [WIDTH-1:0]  OP1_ADDRESS,
   input  logic [WIDTH-1:0]  ALU_RESULT_UPPER,
   input  logic [WIDTH-1:0]  ALU_RESULT_LOWER,
   input  logic [WIDTH-1:0]  MEM_DATA,
   output logic              RF_WE,
   output logic [ADDR_W-1:0] RF_WADDR,
   output logic [WIDTH-1:0]  RF_WDATA,
   output logic [15:0]       INSTR_COUNT,
   output logic              ILLEGAL
);

   localparam logic [ADDR_W-1:0] UPPER_ADDR = ADDR_W'(UPPER_DEST);

   wb_state_t         state, state_next;
   logic [WIDTH-1:0]  hold, hold_next;
   logic              we_next;
   logic [ADDR_W-1:0] waddr_next;
   logic [WIDTH-1:0]  wdata_next;
   logic [15:0]       count_next;
   logic              illegal_next;
   logic [WIDTH-1:0]  sel_data;
   logic              accept;
   logic              reg_write, mem_to_reg, wide;
   logic              unused_bits;

   assign reg_write  = WB_CTRL[WB_REG_WRITE];
   assign mem_to_reg = WB_CTRL[WB_MEM_TO_REG];
   assign wide       = WB_CTRL[WB_WIDE];
   assign IN_READY   = (state == IDLE);
   assign accept     = IN_VALID && IN_READY;

   // Control bits above WIDE and address bits above ADDR_W carry no meaning here.
   assign unused_bits = ^{WB_CTRL[WIDTH-1:3], OP1_ADDRESS[WIDTH-1:ADDR_W]};

   wb_data_select #(.WIDTH(WIDTH)) u_data_select (
      .mem_to_reg (mem_to_reg),
      .alu_lower  (ALU_RESULT_LOWER),
      .mem_data   (MEM_DATA),
      .result     (sel_data)
   );

   // Next-state and next-output decode; a wide ALU result parks its upper half for one extra cycle.
   always_comb begin
      state_next   = state;
      hold_next    = hold;
      we_next      = 1'b0;
      waddr_next   = RF_WADDR;
      wdata_next   = RF_WDATA;
      count_next   = INSTR_COUNT;
      illegal_next = ILLEGAL;
      case (state)
         IDLE: begin
            if (accept) begin
               count_next = INSTR_COUNT + 16'd1;
               if (wide && mem_to_reg) begin
                  illegal_next = 1'b1;
               end
               if (reg_write) begin
                  we_next    = 1'b1;
                  waddr_next = OP1_ADDRESS[ADDR_W-1:0];
                  wdata_next = sel_data;
                  if (wide && !mem_to_reg) begin
                     hold_next  = ALU_RESULT_UPPER;
                     state_next = HI_PEND;
                  end
               end
            end
         end
         HI_PEND: begin
            we_next    = 1'b1;
            waddr_next = UPPER_ADDR;
            wdata_next = hold;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, hold register, write port, counter and sticky flag registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         hold        <= '0;
         RF_WE       <= 1'b0;
         RF_WADDR    <= '0;
         RF_WDATA    <= '0;
         INSTR_COUNT <= '0;
         ILLEGAL     <= 1'b0;
      end else begin
         state       <= state_next;
         hold        <= hold_next;
         RF_WE       <= we_next;
         RF_WADDR    <= waddr_next;
         RF_WDATA    <= wdata_next;
         INSTR_COUNT <= count_next;
         ILLEGAL     <= illegal_next;
      end
   end

endmodule

// File: tb/tb_wb_writeback_sequencer.sv
// tb/tb_wb_writeback_sequencer.sv - scoreboard bench for the write-back sequencer
module tb_wb_writeback_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [15:0] WB_CTRL = '0;
   logic [15:0] OP1_ADDRESS = '0;
   logic [15:0] ALU_RESULT_UPPER = '0;
   logic [15:0] ALU_RESULT_LOWER = '0;
   logic [15:0] MEM_DATA = '0;
   logic        RF_WE;
   logic [3:0]  RF_WADDR;
   logic [15:0] RF_WDATA;
   logic [15:0] INSTR_COUNT;
   logic        ILLEGAL;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_count = '0;

   wb_writeback_sequencer dut (
      .CLK              (CLK),
      .RST              (RST),
      .IN_VALID         (IN_VALID),
      .IN_READY         (IN_READY),
      .WB_CTRL          (WB_CTRL),
      .OP1_ADDRESS      (OP1_ADDRESS),
      .ALU_RESULT_UPPER (ALU_RESULT_UPPER),
      .ALU_RESULT_LOWER (ALU_RESULT_LOWER),
      .MEM_DATA         (MEM_DATA),
      .RF_WE            (RF_WE),
      .RF_WADDR         (RF_WADDR),
      .RF_WDATA         (RF_WDATA),
      .INSTR_COUNT      (INSTR_COUNT),
      .ILLEGAL          (ILLEGAL)
   );

   always #5 CLK = ~CLK;

   // Every register-file write must match the oldest expected write, in order.
   always @(negedge CLK) begin
      if (RST && RF_WE) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=%h, none expected", RF_WADDR, RF_WDATA);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (RF_WADDR !== e.addr || RF_WDATA !== e.data) begin
               errors++;
               $display("FAIL write_content: got addr=%0d data=%h, want addr=%0d data=%h",
                        RF_WADDR, RF_WDATA, e.addr, e.data);
            end
         end
      end
   end

   // Presents one instruction and holds it until accepted; returns stall cycles seen.
   task automatic issue(input logic [15:0] ctrl, input logic [15:0] op1, input logic [15:0] up,
                        input logic [15:0] lo, input logic [15:0] mem, output int waits);
      exp_t e;
      WB_CTRL = ctrl;
      OP1_ADDRESS = op1;
      ALU_RESULT_UPPER = up;
      ALU_RESULT_LOWER = lo;
      MEM_DATA = mem;
      IN_VALID = 1'b1;
      waits = 0;
      @(negedge CLK);
      while (!IN_READY && waits < 20) begin
         waits++;
         @(negedge CLK);
      end
      if (!IN_READY) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: IN_READY=%b after %0d cycles, want 1", IN_READY, waits);
      end
      if (ctrl[0]) begin
         e.addr = op1[3:0];
         e.data = ctrl[1] ? mem : lo;
         sb.push_back(e);
         if (ctrl[2] && !ctrl[1]) begin
            e.addr = 4'd0;
            e.data = up;
            sb.push_back(e);
         end
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      exp_count = exp_count + 16'd1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset;
      RST = 1'b0;
      idle_cycles(3);
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b0 || RF_WADDR !== 4'd0 || RF_WDATA !== 16'd0 ||
          INSTR_COUNT !== 16'd0 || ILLEGAL !== 1'b0 || IN_READY !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: we=%b addr=%0d data=%h cnt=%h ill=%b rdy=%b, want 0 0 0 0 0 1",
                  RF_WE, RF_WADDR, RF_WDATA, INSTR_COUNT, ILLEGAL, IN_READY);
      end
      @(posedge CLK);
      #1;
      RST = 1'b1;
      exp_count = '0;
      idle_cycles(2);
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b0 || IN_READY !== 1'b1 || INSTR_COUNT !== 16'd0) begin
         errors++;
         $display("FAIL reset_release: we=%b rdy=%b cnt=%h, want 0 1 0", RF_WE, IN_READY, INSTR_COUNT);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_alu_write;
      int w;
      issue(16'h0001, 16'h0005, 16'h9999, 16'h1234, 16'h7777, w);
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b1 || RF_WADDR !== 4'd5 || RF_WDATA !== 16'h1234) begin
         errors++;
         $display("FAIL alu_latency: we=%b addr=%0d data=%h, want 1 5 1234", RF_WE, RF_WADDR, RF_WDATA);
      end
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b0) begin
         errors++;
         $display("FAIL alu_pulse: we=%b, want 0", RF_WE);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_load_write;
      int w;
      issue(16'h0003, 16'h0003, 16'h1111, 16'h2222, 16'hBEEF, w);
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b1 || RF_WADDR !== 4'd3 || RF_WDATA !== 16'hBEEF) begin
         errors++;
         $display("FAIL load_write: we=%b addr=%0d data=%h, want 1 3 beef", RF_WE, RF_WADDR, RF_WDATA);
      end
      idle_cycles(1);
   endtask

   task automatic test_back_to_back;
      int w;
      issue(16'h0005, 16'h0007, 16'hAAAA, 16'h5555, 16'h0000, w);
      checks++;
      if (w !== 0) begin
         errors++;
         $display("FAIL wide_accept_wait: waits=%0d, want 0", w);
      end
      issue(16'h0001, 16'h0009, 16'h0000, 16'h0F0F, 16'h0000, w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL wide_stall: waits=%0d, want 1", w);
      end
      issue(16'h0005, 16'h0000, 16'hC0DE, 16'h0123, 16'h0000, w);
      idle_cycles(3);
      checks++;
      if (sb.size() != 0 || INSTR_COUNT !== exp_count) begin
         errors++;
         $display("FAIL stream_drain: pending=%0d cnt=%h, want 0 %h", sb.size(), INSTR_COUNT, exp_count);
      end
   endtask

   task automatic test_illegal_nowrite;
      int w;
      issue(16'h0007, 16'h0002, 16'h3333, 16'h2222, 16'h1111, w);
      @(negedge CLK);
      checks++;
      if (IN_READY !== 1'b1 || ILLEGAL !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag: rdy=%b ill=%b, want 1 1", IN_READY, ILLEGAL);
      end
      @(posedge CLK);
      #1;
      issue(16'h0004, 16'h0006, 16'h4444, 16'h5555, 16'h6666, w);
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b0 || IN_READY !== 1'b1 || INSTR_COUNT !== exp_count) begin
         errors++;
         $display("FAIL nowrite_wide: we=%b rdy=%b cnt=%h, want 0 1 %h", RF_WE, IN_READY, INSTR_COUNT, exp_count);
      end
      idle_cycles(3);
      @(negedge CLK);
      checks++;
      if (ILLEGAL !== 1'b1) begin
         errors++;
         $display("FAIL illegal_sticky: ill=%b, want 1", ILLEGAL);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset_in_hi_pend;
      int w;
      issue(16'h0005, 16'h0004, 16'hDEAD, 16'hFACE, 16'h0000, w);
      RST = 1'b0;
      sb.delete();
      exp_count = '0;
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b0 || IN_READY !== 1'b1 || ILLEGAL !== 1'b0) begin
         errors++;
         $display("FAIL reset_hi_pend: we=%b rdy=%b ill=%b, want 0 1 0", RF_WE, IN_READY, ILLEGAL);
      end
      @(posedge CLK);
      #1;
      RST = 1'b1;
      idle_cycles(3);
      @(negedge CLK);
      checks++;
      if (RF_WE !== 1'b0 || INSTR_COUNT !== 16'd0) begin
         errors++;
         $display("FAIL reset_drop_upper: we=%b cnt=%h, want 0 0", RF_WE, INSTR_COUNT);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_counter_wrap;
      WB_CTRL = 16'h0000;
      IN_VALID = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         @(posedge CLK);
         #1;
      end
      IN_VALID = 1'b0;
      exp_count = 16'hFFFF;
      idle_cycles(4);
      @(negedge CLK);
      checks++;
      if (INSTR_COUNT !== exp_count) begin
         errors++;
         $display("FAIL count_idle_hold: cnt=%h, want %h", INSTR_COUNT, exp_count);
      end
      IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      exp_count = exp_count + 16'd1;
      @(negedge CLK);
      checks++;
      if (INSTR_COUNT !== 16'h0000 || INSTR_COUNT !== exp_count) begin
         errors++;
         $display("FAIL count_wrap: cnt=%h, want 0000", INSTR_COUNT);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      test_reset;
      test_alu_write;
      test_load_write;
      test_back_to_back;
      test_illegal_nowrite;
      test_reset_in_hi_pend;
      test_counter_wrap;
      idle_cycles(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_writes: pending=%0d, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_writeback_sequencer.md
Name: wb_writeback_sequencer

Overview:
- Consumer end of the MEM/WB pipeline register. Takes the buffered write-back control word, destination address, the 32-bit ALU result (upper and lower halves) and memory load data.
- Drives the register file's single write port.
- 32-bit results (multiply/divide) need two sequenced writes through that one port, so the block stalls upstream for one cycle when it sees one.
- Sits between the MEM/WB buffer outputs and the register file write port.

Parameters:
- WIDTH, 16, datapath and control-word width
- ADDR_W, 4, register-file address width; destination is OP1_ADDRESS[ADDR_W-1:0]
- UPPER_DEST, 0, register address that receives the upper half of a wide result

Ports:
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-low
- IN_VALID  input  1  MEM/WB buffer holds a valid instruction this cycle
- IN_READY  output  1  block accepts the instruction this cycle; low while the upper-half write is pending
- WB_CTRL  input  WIDTH  write-back control word from the buffer
- OP1_ADDRESS  input  WIDTH  destination register; only the low ADDR_W bits are used
- ALU_RESULT_UPPER  input  WIDTH  upper half of the ALU result
- ALU_RESULT_LOWER  input  WIDTH  lower half of the ALU result
- MEM_DATA  input  WIDTH  load data
- RF_WE  output  1  register-file write enable, registered
- RF_WADDR  output  ADDR_W  register-file write address, registered
- RF_WDATA  output  WIDTH  register-file write data, registered
- INSTR_COUNT  output  16  count of accepted instructions, wraps
- ILLEGAL  output  1  sticky flag: WIDE and MEM_TO_REG seen set together

Behaviour:
- Control bits:
  - WB_CTRL[0] REG_WRITE
  - WB_CTRL[1] MEM_TO_REG
  - WB_CTRL[2] WIDE
  - All other bits are ignored.
- States:
  - IDLE
  - HI_PEND
- IN_READY is combinational and equals (state == IDLE).
- Accept occurs when IN_VALID and IN_READY are both high at a rising CLK edge.
- Reset (RST low, asynchronous):
  - state = IDLE
  - RF_WE = 0, RF_WADDR = 0, RF_WDATA = 0
  - INSTR_COUNT = 0, ILLEGAL = 0
  - upper hold register = 0
- Accept in IDLE:
  - INSTR_COUNT increments by 1 and wraps from 0xFFFF to 0x0000.
  - If REG_WRITE = 0: RF_WE <= 0 on the next edge; state stays IDLE.
  - If REG_WRITE = 1:
    - RF_WE <= 1.
    - RF_WADDR <= OP1_ADDRESS[ADDR_W-1:0].
    - RF_WDATA <= MEM_DATA if MEM_TO_REG = 1, otherwise ALU_RESULT_LOWER.
  - If REG_WRITE = 1, WIDE = 1 and MEM_TO_REG = 0:
    - Capture ALU_RESULT_UPPER into the hold register.
    - state <= HI_PEND.
- HI_PEND, on the next edge:
  - RF_WE <= 1, RF_WADDR <= UPPER_DEST, RF_WDATA <= hold register.
  - state <= IDLE.
  - IN_VALID is ignored in this state (IN_READY = 0); upstream must hold its data.
- No accept in IDLE: RF_WE <= 0 on the next edge.
- Latency:
  - Lower/normal write appears on RF_* one cycle after accept.
  - Upper write appears two cycles after accept.
  - Throughput: one instruction per cycle; a wide instruction costs 2 cycles.
- Boundary and illegal cases:
  - WIDE = 1 with MEM_TO_REG = 1:
    - MEM_TO_REG wins and a single write of MEM_DATA occurs.
    - ILLEGAL is set to 1 and stays set until reset.
  - WIDE = 1 with REG_WRITE = 0: no writes and no stall; INSTR_COUNT still increments.
  - OP1 address equal to UPPER_DEST on a wide write: both writes are issued, and the upper half ends in the register (last write wins).
  - Reset asserted while in HI_PEND: the pending upper write is dropped; state returns to IDLE and RF_WE = 0.
- Each RF_WE pulse lasts exactly one cycle per write; there is no combinational path from inputs to RF_*.

Decomposition:
- Shared package wb_pkg:
  - bit indices WB_REG_WRITE = 0, WB_MEM_TO_REG = 1, WB_WIDE = 2
  - state encoding: IDLE = 1'b0, HI_PEND = 1'b1
  - default UPPER_DEST
- One natural sub-module, wb_data_select: combinational result mux choosing MEM_DATA or ALU_RESULT_LOWER.
- The FSM, hold register, counter and sticky flag stay in the top level.

Test Plan:
- Reset mid-stream: hold RST low, pulse it, then release → all outputs 0 and IN_READY = 1; during HI_PEND, assert RST → no upper write appears; after release RF_WE = 0 and INSTR_COUNT = 0.
- ALU write: WB_CTRL = 0x0001, OP1 = 0x0005, LOWER = 0x1234, one accept → next cycle RF_WE = 1, RF_WADDR = 5, RF_WDATA = 0x1234; the cycle after, RF_WE = 0.
- Load write: WB_CTRL = 0x0003, MEM_DATA = 0xBEEF, OP1 = 0x0003 → RF_WADDR = 3, RF_WDATA = 0xBEEF.
- Wide write with back-to-back stream: WB_CTRL = 0x0005, OP1 = 7, UPPER = 0xAAAA, LOWER = 0x5555, followed by a normal instruction held valid:
  - cycle+1: write 7 ← 0x5555, IN_READY = 0
  - cycle+2: write 0 ← 0xAAAA
  - next instruction accepted only at cycle+2; no instruction is lost or duplicated.
- Illegal combo and no-write: WB_CTRL = 0x0007 → single write of MEM_DATA, no stall, ILLEGAL = 1 and stays 1; WB_CTRL = 0x0004 → no RF_WE, INSTR_COUNT increments.
- Counter wrap: 65536 accepts → INSTR_COUNT returns to 0x0000; IN_VALID = 0 cycles do not count.
